// File: rtl/axilite_pkg.sv
// Shared types and helpers for the AXI4-Lite memory slave.
package axilite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Widest data bus the merge helper supports; callers zero-extend into it.
    localparam int unsigned MaxDataWidth = 1024;
    localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

    // Defaults for the common 32-bit, 64-word configuration.
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 64;
    localparam int unsigned DefStrbWidth = DefDataWidth / 8;
    localparam int unsigned DefIdxWidth  = $clog2(DefDepth);

    function automatic int unsigned byte_lanes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // A single-word memory still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Take new bytes where the strobe is set, keep old bytes elsewhere.
    function automatic logic [MaxDataWidth-1:0] strb_merge(
        input logic [MaxDataWidth-1:0] old_word,
        input logic [MaxDataWidth-1:0] new_word,
        input logic [MaxStrbWidth-1:0] strb
    );
        logic [MaxDataWidth-1:0] result;
        for (int unsigned i = 0; i < MaxStrbWidth; i++) begin
            result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/bytewise_ram.sv
// Word-addressed RAM with per-byte write enables, one synchronous read port and
// one write port. A read and write to the same word at one edge returns old data.
module bytewise_ram
    import axilite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned StrbW     = byte_lanes(DATA_WIDTH),
    localparam int unsigned IdxW      = idx_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  re_i,
    input  logic [IdxW-1:0]       raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  we_i,
    input  logic [IdxW-1:0]       waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [StrbW-1:0]      wstrb_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [MaxDataWidth-1:0] old_ext;
    logic [MaxDataWidth-1:0] new_ext;
    logic [MaxStrbWidth-1:0] strb_ext;
    logic [MaxDataWidth-1:0] merged_ext;
    logic                    unused_merge_hi;

    // Read old contents and write enabled bytes at the same edge.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int unsigned i = 0; i < StrbW; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Merged word as it will look after the write, for the notification port.
    always_comb begin
        old_ext                    = '0;
        new_ext                    = '0;
        strb_ext                   = '0;
        old_ext[DATA_WIDTH-1:0]    = mem_q[waddr_i];
        new_ext[DATA_WIDTH-1:0]    = wdata_i;
        strb_ext[StrbW-1:0]        = wstrb_i;
        merged_ext                 = strb_merge(old_ext, new_ext, strb_ext);
    end

    assign merged_o        = merged_ext[DATA_WIDTH-1:0];
    assign rdata_o         = rdata_q;
    assign unused_merge_hi = ^merged_ext[MaxDataWidth-1:DATA_WIDTH];

endmodule

// File: rtl/axilite_mem_slave.sv
// AXI4-Lite memory slave: one-beat AW/W buffers, held B/R responses, SLVERR on
// out-of-range words, and a one-cycle notification of every committed write.
module axilite_mem_slave
    import axilite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned StrbW     = byte_lanes(DATA_WIDTH),
    localparam int unsigned IdxW      = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [StrbW-1:0]      wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_w,
    output logic [IdxW-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data
);

    localparam int unsigned         OffW   = $clog2(StrbW);
    localparam logic [ADDR_WIDTH:0] DepthA = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  aw_full_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_full_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [StrbW-1:0]      w_strb_q;
    logic                  bvalid_q;
    resp_t                 bresp_q;
    logic                  rvalid_q;
    resp_t                 rresp_q;
    logic                  rd_ok_q;
    logic                  mem_w_q;
    logic [IdxW-1:0]       mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;

    logic [ADDR_WIDTH-1:0] aw_word;
    logic [ADDR_WIDTH-1:0] ar_word;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic                  commit;
    logic                  ar_hs;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] ram_merged;

    assign aw_word     = aw_addr_q >> OffW;
    assign ar_word     = araddr >> OffW;
    assign aw_in_range = {1'b0, aw_word} < DepthA;
    assign ar_in_range = {1'b0, ar_word} < DepthA;

    assign awready = ~aw_full_q;
    assign wready  = ~w_full_q;
    assign arready = ~rvalid_q | rready;
    // A pending response blocks the next commit until the master takes it.
    assign commit  = aw_full_q & w_full_q & (~bvalid_q | bready);
    assign ar_hs   = arvalid & arready;

    bytewise_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i    (clk),
        .re_i     (ar_hs & ar_in_range),
        .raddr_i  (ar_word[IdxW-1:0]),
        .rdata_o  (ram_rdata),
        .we_i     (commit & aw_in_range),
        .waddr_i  (aw_word[IdxW-1:0]),
        .wdata_i  (w_data_q),
        .wstrb_i  (w_strb_q),
        .merged_o (ram_merged)
    );

    // AW/W holding buffers: fill on handshake, drain together on commit.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (commit) begin
                aw_full_q <= 1'b0;
            end else if (awvalid && !aw_full_q) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (commit) begin
                w_full_q <= 1'b0;
            end else if (wvalid && !w_full_q) begin
                w_full_q <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    // Write response: set on commit, held until bready.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_in_range ? OKAY : SLVERR;
        end else if (bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read response: loaded on AR handshake, held until rready.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rd_ok_q  <= 1'b0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_in_range ? OKAY : SLVERR;
            rd_ok_q  <= ar_in_range;
        end else if (rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // Commit notification: one-cycle pulse, index/word held until the next one.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            mem_w_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_w_q <= commit & aw_in_range;
            if (commit && aw_in_range) begin
                mem_addr_q <= aw_word[IdxW-1:0];
                mem_data_q <= ram_merged;
            end
        end
    end

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rresp    = rresp_q;
    // RAM output register has no reset; gate it so reset and SLVERR read as 0.
    assign rdata    = rd_ok_q ? ram_rdata : '0;
    assign mem_w    = mem_w_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule
